// File: rtl/counter_core.sv
// counter_core: 32-bit up-counter with cap compare, sticky overflow and wrap pulse.
// Optional tick prescaler is enabled by defining COUNTER_PRESCALER_EN.
module counter_core #(
   parameter int unsigned PRESCALE_DIV = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        auto_restart,
   input  logic        enable,
   input  logic [31:0] cap,
   input  logic        load,
   input  logic [31:0] load_val,
   output logic        overflow,
   output logic        wrap,
   output logic [31:0] count
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   if (PRESCALE_DIV < 2) begin : g_bad_div
      $error("counter_core: PRESCALE_DIV must be at least 2");
   end

   logic [1:0]  state_q, state_d;
   logic [31:0] count_q, count_d;
   logic        overflow_q, overflow_d;
   logic        wrap_q, wrap_d;
   logic        run_active;
   logic        tick;

   assign run_active = (state_q == ST_RUN) && enable;

`ifdef COUNTER_PRESCALER_EN
   localparam int unsigned PW = $clog2(PRESCALE_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE_DIV - 1);

   logic [PW-1:0] presc_q, presc_d;

   // The prescaler only advances while counting is live; load and leaving RUN restart the spacing.
   always_comb begin
      presc_d = '0;
      tick    = 1'b0;
      if (run_active && !load) begin
         if (presc_q == PRESC_LAST) begin
            tick = 1'b1;
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end
`else
   assign tick = run_active;
`endif

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      state_d    = state_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      wrap_d     = 1'b0;
      if (load) begin
         count_d    = load_val;
         overflow_d = 1'b0;
         state_d    = enable ? ST_RUN : ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (enable) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (!enable) begin
                  state_d = ST_IDLE;
               end else if (tick) begin
                  if (count_q == cap) begin
                     overflow_d = 1'b1;
                     wrap_d     = 1'b1;
                     if (auto_restart) begin
                        count_d = '0;
                     end else begin
                        state_d = ST_HALT;
                     end
                  end else begin
                     // Values loaded above cap roll through 2^32 without flagging overflow.
                     count_d = count_q + 32'd1;
                  end
               end
            end
            ST_HALT: begin
               if (!enable) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         overflow_q <= 1'b0;
         wrap_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         wrap_q     <= wrap_d;
      end
   end

   assign count    = count_q;
   assign overflow = overflow_q;
   assign wrap     = wrap_q;

endmodule
